// File: rtl/alu_decode_queue_pkg.sv
// Shared MIPS decode constants for alu_decode_queue: opcode/funct/rt encodings,
// alucontrol codes (EXE_*_OP), hazard FSM states and the HI/LO-class predicate.
package alu_decode_queue_pkg;

    // Primary opcodes
    localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
    localparam logic [5:0] EXE_REGIMM_INST  = 6'b000001;
    localparam logic [5:0] EXE_J            = 6'b000010;
    localparam logic [5:0] EXE_JAL          = 6'b000011;
    localparam logic [5:0] EXE_BEQ          = 6'b000100;
    localparam logic [5:0] EXE_BNE          = 6'b000101;
    localparam logic [5:0] EXE_BLEZ         = 6'b000110;
    localparam logic [5:0] EXE_BGTZ         = 6'b000111;
    localparam logic [5:0] EXE_ADDI         = 6'b001000;
    localparam logic [5:0] EXE_ADDIU        = 6'b001001;
    localparam logic [5:0] EXE_SLTI         = 6'b001010;
    localparam logic [5:0] EXE_SLTIU        = 6'b001011;
    localparam logic [5:0] EXE_ANDI         = 6'b001100;
    localparam logic [5:0] EXE_ORI          = 6'b001101;
    localparam logic [5:0] EXE_XORI         = 6'b001110;
    localparam logic [5:0] EXE_LUI          = 6'b001111;
    localparam logic [5:0] EXE_LW           = 6'b100011;
    localparam logic [5:0] EXE_SW           = 6'b101011;

    // SPECIAL funct field
    localparam logic [5:0] EXE_SLL   = 6'b000000;
    localparam logic [5:0] EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA   = 6'b000011;
    localparam logic [5:0] EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV  = 6'b000110;
    localparam logic [5:0] EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_JR    = 6'b001000;
    localparam logic [5:0] EXE_JALR  = 6'b001001;
    localparam logic [5:0] EXE_MFHI  = 6'b010000;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MFLO  = 6'b010010;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_ADD   = 6'b100000;
    localparam logic [5:0] EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB   = 6'b100010;
    localparam logic [5:0] EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_AND   = 6'b100100;
    localparam logic [5:0] EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR   = 6'b100110;
    localparam logic [5:0] EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLT   = 6'b101010;
    localparam logic [5:0] EXE_SLTU  = 6'b101011;

    // REGIMM rt field
    localparam logic [4:0] EXE_BLTZ   = 5'b00000;
    localparam logic [4:0] EXE_BGEZ   = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL = 5'b10001;

    // alucontrol codes
    localparam logic [7:0] EXE_NOP_OP    = 8'h00;
    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [7:0] EXE_XOR_OP    = 8'h26;
    localparam logic [7:0] EXE_NOR_OP    = 8'h27;
    localparam logic [7:0] EXE_ANDI_OP   = 8'h59;
    localparam logic [7:0] EXE_ORI_OP    = 8'h5A;
    localparam logic [7:0] EXE_XORI_OP   = 8'h5B;
    localparam logic [7:0] EXE_LUI_OP    = 8'h5C;
    localparam logic [7:0] EXE_SLL_OP    = 8'h7C;
    localparam logic [7:0] EXE_SLLV_OP   = 8'h04;
    localparam logic [7:0] EXE_SRL_OP    = 8'h02;
    localparam logic [7:0] EXE_SRLV_OP   = 8'h06;
    localparam logic [7:0] EXE_SRA_OP    = 8'h03;
    localparam logic [7:0] EXE_SRAV_OP   = 8'h07;
    localparam logic [7:0] EXE_MFHI_OP   = 8'h10;
    localparam logic [7:0] EXE_MTHI_OP   = 8'h11;
    localparam logic [7:0] EXE_MFLO_OP   = 8'h12;
    localparam logic [7:0] EXE_MTLO_OP   = 8'h13;
    localparam logic [7:0] EXE_SLT_OP    = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP   = 8'h2B;
    localparam logic [7:0] EXE_SLTI_OP   = 8'h57;
    localparam logic [7:0] EXE_SLTIU_OP  = 8'h58;
    localparam logic [7:0] EXE_ADD_OP    = 8'h20;
    localparam logic [7:0] EXE_ADDU_OP   = 8'h21;
    localparam logic [7:0] EXE_SUB_OP    = 8'h22;
    localparam logic [7:0] EXE_SUBU_OP   = 8'h23;
    localparam logic [7:0] EXE_ADDI_OP   = 8'h55;
    localparam logic [7:0] EXE_ADDIU_OP  = 8'h56;
    localparam logic [7:0] EXE_MULT_OP   = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP  = 8'h19;
    localparam logic [7:0] EXE_DIV_OP    = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP   = 8'h1B;
    localparam logic [7:0] EXE_J_OP      = 8'h4F;
    localparam logic [7:0] EXE_JAL_OP    = 8'h50;
    localparam logic [7:0] EXE_JALR_OP   = 8'h09;
    localparam logic [7:0] EXE_JR_OP     = 8'h08;
    localparam logic [7:0] EXE_BEQ_OP    = 8'h51;
    localparam logic [7:0] EXE_BNE_OP    = 8'h52;
    localparam logic [7:0] EXE_BLEZ_OP   = 8'h53;
    localparam logic [7:0] EXE_BGTZ_OP   = 8'h54;
    localparam logic [7:0] EXE_BLTZ_OP   = 8'h40;
    localparam logic [7:0] EXE_BGEZ_OP   = 8'h41;
    localparam logic [7:0] EXE_BLTZAL_OP = 8'h4A;
    localparam logic [7:0] EXE_BGEZAL_OP = 8'h4B;
    localparam logic [7:0] EXE_LW_OP     = 8'hE3;
    localparam logic [7:0] EXE_SW_OP     = 8'hEB;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic hilo;
        logic mul;
        logic div;
        logic ri;
    } entry_flags_t;

    function automatic logic is_hilo_class(input logic [7:0] op);
        return op inside {EXE_MFHI_OP, EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP,
                          EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    endfunction

endpackage

// File: rtl/alu_decode_queue_alu_op_lut.sv
// Combinational MIPS op/funct/rt -> alucontrol lookup with HI/LO, mul, div and
// reserved-instruction flags. out ri is only raised when ALU_DECODE_RI_EN is defined.
module alu_op_lut
    import alu_decode_queue_pkg::*;
#(
    parameter int ALUOP_W = 8
) (
    input  logic [31:0]        instr,
    output logic [ALUOP_W-1:0] alucontrol,
    output logic               hilo,
    output logic               mul,
    output logic               div,
    output logic               ri
);

`ifdef ALU_DECODE_RI_EN
    localparam logic RI_EN = 1'b1;
`else
    localparam logic RI_EN = 1'b0;
`endif

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [7:0] code;
    logic       known;
    logic       unused_fields;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign unused_fields = ^{instr[25:21], instr[15:6]};

    always_comb begin
        code  = EXE_NOP_OP;
        known = 1'b1;
        unique case (op)
            EXE_SPECIAL_INST: begin
                case (funct)
                    EXE_AND:   code = EXE_AND_OP;
                    EXE_OR:    code = EXE_OR_OP;
                    EXE_XOR:   code = EXE_XOR_OP;
                    EXE_NOR:   code = EXE_NOR_OP;
                    EXE_SLL:   code = EXE_SLL_OP;
                    EXE_SRL:   code = EXE_SRL_OP;
                    EXE_SRA:   code = EXE_SRA_OP;
                    EXE_SLLV:  code = EXE_SLLV_OP;
                    EXE_SRLV:  code = EXE_SRLV_OP;
                    EXE_SRAV:  code = EXE_SRAV_OP;
                    EXE_MFHI:  code = EXE_MFHI_OP;
                    EXE_MFLO:  code = EXE_MFLO_OP;
                    EXE_MTHI:  code = EXE_MTHI_OP;
                    EXE_MTLO:  code = EXE_MTLO_OP;
                    EXE_ADD:   code = EXE_ADD_OP;
                    EXE_ADDU:  code = EXE_ADDU_OP;
                    EXE_SUB:   code = EXE_SUB_OP;
                    EXE_SUBU:  code = EXE_SUBU_OP;
                    EXE_SLT:   code = EXE_SLT_OP;
                    EXE_SLTU:  code = EXE_SLTU_OP;
                    EXE_MULT:  code = EXE_MULT_OP;
                    EXE_MULTU: code = EXE_MULTU_OP;
                    EXE_DIV:   code = EXE_DIV_OP;
                    EXE_DIVU:  code = EXE_DIVU_OP;
                    EXE_JR:    code = EXE_JR_OP;
                    EXE_JALR:  code = EXE_JALR_OP;
                    default:   known = 1'b0;
                endcase
            end
            EXE_REGIMM_INST: begin
                case (rt)
                    EXE_BLTZ:   code = EXE_BLTZ_OP;
                    EXE_BGEZ:   code = EXE_BGEZ_OP;
                    EXE_BLTZAL: code = EXE_BLTZAL_OP;
                    EXE_BGEZAL: code = EXE_BGEZAL_OP;
                    default:    known = 1'b0;
                endcase
            end
            EXE_ANDI:  code = EXE_ANDI_OP;
            EXE_ORI:   code = EXE_ORI_OP;
            EXE_XORI:  code = EXE_XORI_OP;
            EXE_LUI:   code = EXE_LUI_OP;
            EXE_ADDI:  code = EXE_ADDI_OP;
            EXE_ADDIU: code = EXE_ADDIU_OP;
            EXE_SLTI:  code = EXE_SLTI_OP;
            EXE_SLTIU: code = EXE_SLTIU_OP;
            EXE_BEQ:   code = EXE_BEQ_OP;
            EXE_BNE:   code = EXE_BNE_OP;
            EXE_BGTZ:  code = EXE_BGTZ_OP;
            EXE_BLEZ:  code = EXE_BLEZ_OP;
            EXE_J:     code = EXE_J_OP;
            EXE_JAL:   code = EXE_JAL_OP;
            EXE_LW:    code = EXE_LW_OP;
            EXE_SW:    code = EXE_SW_OP;
            default:   known = 1'b0;
        endcase
    end

    assign alucontrol = ALUOP_W'(code);
    assign hilo       = is_hilo_class(code);
    assign mul        = (code == EXE_MULT_OP) || (code == EXE_MULTU_OP);
    assign div        = (code == EXE_DIV_OP)  || (code == EXE_DIVU_OP);
    assign ri         = RI_EN & ~known;

endmodule

// File: rtl/alu_decode_queue.sv
// Registered MIPS ALU decoder: decode on input fire into a DEPTH-entry queue, with a
// HI/LO hazard counter holding HI/LO-class heads while a MULT/DIV is busy.
// Optional reserved-instruction flagging on out_ri via ALU_DECODE_RI_EN.
module alu_decode_queue
    import alu_decode_queue_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 36
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] out_alucontrol,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_hilo,
    output logic               out_ri
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HZ_W  = $clog2(DIV_LAT + 1);

    logic [ALUOP_W-1:0] dec_alu;
    entry_flags_t       dec_flags;

    alu_op_lut #(
        .ALUOP_W (ALUOP_W)
    ) u_lut (
        .instr      (in_instr),
        .alucontrol (dec_alu),
        .hilo       (dec_flags.hilo),
        .mul        (dec_flags.mul),
        .div        (dec_flags.div),
        .ri         (dec_flags.ri)
    );

    logic [ALUOP_W-1:0] alu_mem  [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    entry_flags_t       flag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    hz_state_e        state_q, state_d;
    logic [HZ_W-1:0]  hz_cnt_q, hz_cnt_d;

    logic               push;
    logic               pop;
    logic               empty;
    logic               hold;
    logic [ALUOP_W-1:0] head_alu;
    logic [TAG_W-1:0]   head_tag;
    entry_flags_t       head_flags;

    // Ready is purely registered: a full queue refuses pushes even if it pops this cycle.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = in_valid & in_ready & ~flush;

    assign head_alu   = alu_mem[rd_ptr_q];
    assign head_tag   = tag_mem[rd_ptr_q];
    assign head_flags = flag_mem[rd_ptr_q];

    assign hold      = (state_q == HZ_BUSY) & head_flags.hilo;
    assign out_valid = ~empty & ~hold;
    assign pop       = out_valid & out_ready;

    assign out_alucontrol = empty ? '0 : head_alu;
    assign out_tag        = empty ? '0 : head_tag;
    assign out_hilo       = ~empty & head_flags.hilo;
    assign out_ri         = ~empty & head_flags.ri;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                alu_mem[gi]  <= dec_alu;
                tag_mem[gi]  <= in_tag;
                flag_mem[gi] <= dec_flags;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The hazard counter ignores flush: an issued mul/div still occupies HI/LO.
    always_comb begin
        state_d  = state_q;
        hz_cnt_d = hz_cnt_q;
        unique case (state_q)
            HZ_IDLE: begin
                if (pop && head_flags.mul) begin
                    state_d  = HZ_BUSY;
                    hz_cnt_d = HZ_W'(MUL_LAT);
                end else if (pop && head_flags.div) begin
                    state_d  = HZ_BUSY;
                    hz_cnt_d = HZ_W'(DIV_LAT);
                end
            end
            HZ_BUSY: begin
                if (hz_cnt_q <= HZ_W'(1)) begin
                    hz_cnt_d = '0;
                    state_d  = HZ_IDLE;
                end else begin
                    hz_cnt_d = hz_cnt_q - HZ_W'(1);
                end
            end
            default: begin
                state_d  = HZ_IDLE;
                hz_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= HZ_IDLE;
            hz_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            hz_cnt_q <= hz_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_decode_queue.sv
// Self-checking bench for alu_decode_queue: directed scenarios plus randomized traffic
// against a queue/countdown reference model. Honours ALU_DECODE_RI_EN for out_ri.
module tb_alu_decode_queue;

    localparam int DEPTH   = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 36;

`ifdef ALU_DECODE_RI_EN
    localparam bit RI_MODEL = 1'b1;
`else
    localparam bit RI_MODEL = 1'b0;
`endif

    localparam logic [31:0] I_ADDIU  = 32'h24010005;
    localparam logic [31:0] I_ORI    = 32'h3422ABCD;
    localparam logic [31:0] I_LW     = 32'h8C230004;
    localparam logic [31:0] I_ADDU   = 32'h00221821;
    localparam logic [31:0] I_AND    = 32'h00221824;
    localparam logic [31:0] I_DIV    = 32'h0022001A;
    localparam logic [31:0] I_MULT   = 32'h00220018;
    localparam logic [31:0] I_MFLO   = 32'h00001812;
    localparam logic [31:0] I_MFHI   = 32'h00001810;
    localparam logic [31:0] I_MTHI   = 32'h00200011;
    localparam logic [31:0] I_BGEZAL = 32'h04710010;
    localparam logic [31:0] I_RIMMX  = 32'h04650010;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_alucontrol;
    logic [31:0] out_tag;
    logic        out_hilo;
    logic        out_ri;

    alu_decode_queue #(
        .ALUOP_W (8),
        .DEPTH   (DEPTH),
        .TAG_W   (32),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alucontrol (out_alucontrol),
        .out_tag        (out_tag),
        .out_hilo       (out_hilo),
        .out_ri         (out_ri)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [7:0]  code;
    } rule_t;

    typedef struct {
        logic [7:0]  alu;
        logic [31:0] tag;
        bit          hilo;
        bit          mul;
        bit          div;
        bit          ri;
    } ent_t;

    rule_t rules[$];
    ent_t  mq[$];
    int    hz_left  = 0;
    int    edge_cnt = 0;
    int    n_pass   = 0;
    int    n_total  = 0;

    function automatic void add_rule(input logic [31:0] mask, input logic [31:0] match,
                                     input logic [7:0] code);
        rule_t r;
        r.mask = mask; r.match = match; r.code = code;
        rules.push_back(r);
    endfunction

    // Decode table: R-type by funct, I/J-type by opcode, REGIMM by rt.
    function automatic void build_rules();
        logic [5:0] rf [26] = '{6'h24,6'h25,6'h26,6'h27,6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,
                                6'h10,6'h12,6'h11,6'h13,6'h20,6'h21,6'h22,6'h23,6'h2A,6'h2B,
                                6'h18,6'h19,6'h1A,6'h1B,6'h08,6'h09};
        logic [7:0] rc [26] = '{8'h24,8'h25,8'h26,8'h27,8'h7C,8'h02,8'h03,8'h04,8'h06,8'h07,
                                8'h10,8'h12,8'h11,8'h13,8'h20,8'h21,8'h22,8'h23,8'h2A,8'h2B,
                                8'h18,8'h19,8'h1A,8'h1B,8'h08,8'h09};
        logic [5:0] io [16] = '{6'h0C,6'h0D,6'h0E,6'h0F,6'h08,6'h09,6'h0A,6'h0B,
                                6'h04,6'h05,6'h07,6'h06,6'h02,6'h03,6'h23,6'h2B};
        logic [7:0] ic [16] = '{8'h59,8'h5A,8'h5B,8'h5C,8'h55,8'h56,8'h57,8'h58,
                                8'h51,8'h52,8'h54,8'h53,8'h4F,8'h50,8'hE3,8'hEB};
        logic [4:0] bt [4]  = '{5'h00,5'h01,5'h10,5'h11};
        logic [7:0] bc [4]  = '{8'h40,8'h41,8'h4A,8'h4B};
        for (int i = 0; i < 26; i++) add_rule(32'hFC00003F, {26'd0, rf[i]}, rc[i]);
        for (int i = 0; i < 16; i++) add_rule(32'hFC000000, {io[i], 26'd0}, ic[i]);
        for (int i = 0; i < 4; i++)  add_rule(32'hFC1F0000, {6'd1, 5'd0, bt[i], 16'd0}, bc[i]);
    endfunction

    function automatic ent_t ref_decode(input logic [31:0] instr, input logic [31:0] tag);
        ent_t e;
        bit found = 1'b0;
        e.alu = 8'h00;
        foreach (rules[i]) begin
            if (!found && ((instr & rules[i].mask) == rules[i].match)) begin
                e.alu = rules[i].code;
                found = 1'b1;
            end
        end
        e.tag  = tag;
        e.hilo = e.alu inside {8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19, 8'h1A, 8'h1B};
        e.mul  = e.alu inside {8'h18, 8'h19};
        e.div  = e.alu inside {8'h1A, 8'h1B};
        e.ri   = RI_MODEL && !found;
        return e;
    endfunction

    function automatic bit model_valid();
        return (mq.size() > 0) && !(hz_left > 0 && mq[0].hilo);
    endfunction

    function automatic logic [31:0] rand_instr();
        int idx;
        if ($urandom_range(7) == 0) return $urandom;
        idx = $urandom_range(rules.size() - 1);
        return ($urandom & ~rules[idx].mask) | rules[idx].match;
    endfunction

    // Drives one cycle from a negedge, advances the model at the posedge, returns at negedge.
    task automatic drive_cycle(input logic v, input logic [31:0] instr, input logic [31:0] tag,
                               input logic ordy, input logic fl);
        bit   do_pop, do_push;
        ent_t e;
        in_valid = v; in_instr = instr; in_tag = tag; out_ready = ordy; flush = fl;
        do_pop  = model_valid() && ordy;
        do_push = v && (mq.size() < DEPTH) && !fl;
        e = ref_decode(instr, tag);
        @(posedge clk);
        edge_cnt++;
        if (do_pop && mq[0].mul)      hz_left = MUL_LAT;
        else if (do_pop && mq[0].div) hz_left = DIV_LAT;
        else if (hz_left > 0)         hz_left--;
        if (do_pop) begin
            $display("pop  tag=%08h alu=%02h hilo=%0b ri=%0b", mq[0].tag, mq[0].alu, mq[0].hilo, mq[0].ri);
            void'(mq.pop_front());
        end
        if (fl) mq.delete();
        else if (do_push) mq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_alucontrol !== 8'h00) $display("FAIL reset_alu: got %h want 00", out_alucontrol); else n_pass++;
        n_total++; if (out_tag !== 32'h0) $display("FAIL reset_tag: got %h want 0", out_tag); else n_pass++;
        n_total++; if (out_hilo !== 1'b0 || out_ri !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", out_hilo, out_ri); else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addiu();
        drive_cycle(1, I_ADDIU, 32'h100, 0, 0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL addiu_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_alucontrol !== 8'h56) $display("FAIL addiu_alu: got %h want 56", out_alucontrol); else n_pass++;
        n_total++; if (out_ri !== 1'b0) $display("FAIL addiu_ri: got %b want 0", out_ri); else n_pass++;
        n_total++; if (out_tag !== 32'h100) $display("FAIL addiu_tag: got %h want 100", out_tag); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL addiu_drained: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_regimm();
        drive_cycle(1, I_BGEZAL, 32'h200, 0, 0);
        n_total++; if (out_alucontrol !== 8'h4B) $display("FAIL bgezal_alu: got %h want 4b", out_alucontrol); else n_pass++;
        drive_cycle(1, I_RIMMX, 32'h204, 1, 0);
        n_total++; if (out_alucontrol !== 8'h00) $display("FAIL regimm_bad_alu: got %h want 00", out_alucontrol); else n_pass++;
        n_total++; if (out_ri !== RI_MODEL) $display("FAIL regimm_bad_ri: got %b want %b", out_ri, RI_MODEL); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        drive_cycle(1, I_ADDU, 32'h1, 0, 0);
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after1: got %b want 1", in_ready); else n_pass++;
        drive_cycle(1, I_ORI, 32'h2, 0, 0);
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_after2: got %b want 0", in_ready); else n_pass++;
        drive_cycle(1, I_LW, 32'h3, 0, 0);
        n_total++; if (out_tag !== 32'h1) $display("FAIL bp_head_order: got %h want 1", out_tag); else n_pass++;
        // Push while full with a simultaneous pop must still be refused.
        drive_cycle(1, I_LW, 32'h3, 1, 0);
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_tag !== 32'h2) $display("FAIL bp_head_second: got %h want 2", out_tag); else n_pass++;
        n_total++; if (out_alucontrol !== 8'h5A) $display("FAIL bp_second_alu: got %h want 5a", out_alucontrol); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_full_push_dropped: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_div_hazard();
        int e0;
        drive_cycle(1, I_DIV, 32'h10, 1, 0);
        drive_cycle(1, I_MFLO, 32'h11, 1, 0);
        e0 = edge_cnt;
        drive_cycle(1, I_ADDU, 32'h12, 1, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL div_mflo_held: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL div_addu_queued: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_tag !== 32'h11) $display("FAIL div_head_tag: got %h want 11", out_tag); else n_pass++;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            drive_cycle(0, 0, 0, 1, 0);
            n_total++; if (out_valid !== model_valid()) $display("FAIL div_wait_valid: got %b want %b", out_valid, model_valid()); else n_pass++;
        end
        n_total++; if (edge_cnt - e0 !== DIV_LAT) $display("FAIL div_latency: got %0d want %0d", edge_cnt - e0, DIV_LAT); else n_pass++;
        n_total++; if (out_alucontrol !== 8'h12 || out_hilo !== 1'b1) $display("FAIL div_mflo_alu: got %h/%b want 12/1", out_alucontrol, out_hilo); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (out_valid !== 1'b1 || out_tag !== 32'h12) $display("FAIL div_addu_next: got %b/%h want 1/12", out_valid, out_tag); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_mult_hazard();
        int e0;
        drive_cycle(1, I_MULT, 32'h30, 1, 0);
        drive_cycle(1, I_AND, 32'h31, 1, 0);
        e0 = edge_cnt;
        n_total++; if (out_valid !== 1'b1 || out_alucontrol !== 8'h24) $display("FAIL mult_and_no_stall: got %b/%h want 1/24", out_valid, out_alucontrol); else n_pass++;
        drive_cycle(1, I_MFHI, 32'h32, 1, 0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL mult_mfhi_held: got %b want 0", out_valid); else n_pass++;
        for (int i = 0; i < 20 && !out_valid; i++) drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (edge_cnt - e0 !== MUL_LAT) $display("FAIL mult_latency: got %0d want %0d", edge_cnt - e0, MUL_LAT); else n_pass++;
        n_total++; if (out_alucontrol !== 8'h10) $display("FAIL mult_mfhi_alu: got %h want 10", out_alucontrol); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        int e0;
        drive_cycle(1, I_DIV, 32'h40, 1, 0);
        drive_cycle(0, 0, 0, 1, 0);
        e0 = edge_cnt;
        drive_cycle(1, I_MFLO, 32'h41, 1, 0);
        drive_cycle(1, I_MTHI, 32'h42, 1, 0);
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_full_before: got %b want 0", in_ready); else n_pass++;
        drive_cycle(1, I_ADDU, 32'h43, 1, 1);
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_empty: got rdy=%b vld=%b want 1/0", in_ready, out_valid); else n_pass++;
        n_total++; if (out_tag !== 32'h0) $display("FAIL flush_tag: got %h want 0", out_tag); else n_pass++;
        drive_cycle(1, I_ADDU, 32'h44, 0, 0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush_refill: got %b want 1", out_valid); else n_pass++;
        drive_cycle(1, I_ADDU, 32'h45, 0, 1);
        n_total++; if (out_valid !== 1'b0 || out_tag !== 32'h0) $display("FAIL flush_overrides_push: got %b/%h want 0/0", out_valid, out_tag); else n_pass++;
        drive_cycle(1, I_MFHI, 32'h46, 1, 0);
        for (int i = 0; i < 100 && !out_valid; i++) drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (edge_cnt - e0 !== DIV_LAT) $display("FAIL flush_hazard_kept: got %0d want %0d", edge_cnt - e0, DIV_LAT); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic v, r, f;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            f = ($urandom_range(39) == 0);
            drive_cycle(v, rand_instr(), $urandom, r, f);
            n_total++; if (out_valid !== model_valid()) $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, model_valid()); else n_pass++;
            n_total++; if (in_ready !== (mq.size() < DEPTH)) $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, mq.size() < DEPTH); else n_pass++;
            if (mq.size() > 0) begin
                n_total++;
                if (out_alucontrol !== mq[0].alu || out_tag !== mq[0].tag || out_hilo !== mq[0].hilo || out_ri !== mq[0].ri)
                    $display("FAIL rand_payload[%0d]: got %h/%h/%b/%b want %h/%h/%b/%b", i, out_alucontrol, out_tag,
                             out_hilo, out_ri, mq[0].alu, mq[0].tag, mq[0].hilo, mq[0].ri);
                else n_pass++;
            end
        end
        for (int i = 0; i < 60 && mq.size() > 0; i++) drive_cycle(0, 0, 0, 1, 0);
        n_total++; if (out_valid !== 1'b0 || mq.size() != 0) $display("FAIL rand_drain: got vld=%b model=%0d want 0/0", out_valid, mq.size()); else n_pass++;
    endtask

    task automatic test_async_reset();
        drive_cycle(1, I_MULT, 32'h50, 1, 0);
        drive_cycle(1, I_ORI, 32'h51, 0, 0);
        drive_cycle(1, I_MTHI, 32'h52, 0, 0);
        #2 resetn = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL areset_clear: got vld=%b rdy=%b want 0/1", out_valid, in_ready); else n_pass++;
        n_total++; if (out_tag !== 32'h0 || out_alucontrol !== 8'h00) $display("FAIL areset_payload: got %h/%h want 0/00", out_tag, out_alucontrol); else n_pass++;
        mq.delete();
        hz_left = 0;
        @(negedge clk);
        resetn = 1'b1;
        drive_cycle(1, I_MFHI, 32'h53, 0, 0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL areset_hazard_cleared: got %b want 1", out_valid); else n_pass++;
        drive_cycle(0, 0, 0, 1, 0);
    endtask

    initial begin
        build_rules();
        test_reset();
        test_addiu();
        test_regimm();
        test_backpressure();
        test_div_hazard();
        test_mult_hazard();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
